// File: rtl/dac_frame_writer_if.sv
// ----------------------------------------------------------------------------
// dac_frame_writer_if
// Groups the limiter-side request signals and the DAC serial/status signals
// of dac_frame_writer.
//   data, clipped, update : word, clip flag and request strobe from the limiter
//   sclk, mosi, cs_n      : serial link to the DAC (sclk idles low, cs_n active low)
//   busy, done            : frame activity and one-cycle completion pulse
//   clip_seen, overrun    : sticky status flags, cleared only by reset
// Modports: master = limiter/testbench side, slave = dac_frame_writer.
// ----------------------------------------------------------------------------
interface dac_frame_writer_if #(
   parameter int unsigned DATA_BITS = 16
);
   logic [DATA_BITS-1:0] data;
   logic                 clipped;
   logic                 update;
   logic                 sclk;
   logic                 mosi;
   logic                 cs_n;
   logic                 busy;
   logic                 done;
   logic                 clip_seen;
   logic                 overrun;

   modport master (
      output data, clipped, update,
      input  sclk, mosi, cs_n, busy, done, clip_seen, overrun
   );

   modport slave (
      input  data, clipped, update,
      output sclk, mosi, cs_n, busy, done, clip_seen, overrun
   );
endinterface

// File: rtl/dac_frame_writer.sv
// ----------------------------------------------------------------------------
// dac_frame_writer
// Serialises {CMD_WORD, data} MSB first to an SPI-style DAC. Each bit spends
// CLK_DIV cycles with sclk low then CLK_DIV cycles with sclk high; the DAC
// samples on the sclk rising edge. After a frame cs_n stays high for CS_GAP
// cycles. Updates arriving while busy go to a single-entry pending buffer
// (newest wins, overwrite flags overrun).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dac_frame_writer_if.slave (request inputs, serial and status outputs)
// All outputs are driven straight from registers.
// ----------------------------------------------------------------------------
module dac_frame_writer #(
   parameter int unsigned          DATA_BITS = 16,
   parameter int unsigned          CMD_BITS  = 8,
   parameter logic [CMD_BITS-1:0]  CMD_WORD  = CMD_BITS'(8'h30),
   parameter int unsigned          CLK_DIV   = 2,
   parameter int unsigned          CS_GAP    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   dac_frame_writer_if.slave bus
);

   localparam int unsigned F     = CMD_BITS + DATA_BITS;
   localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
   localparam int unsigned BIT_W = $clog2(F + 1);
   localparam int unsigned GAP_W = $clog2(CS_GAP + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t               state_q,     state_d;
   logic [F-1:0]         shreg_q,     shreg_d;
   logic [DIV_W-1:0]     div_cnt_q,   div_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q,   gap_cnt_d;
   logic                 sclk_q,      sclk_d;
   logic                 cs_n_q,      cs_n_d;
   logic                 busy_q,      busy_d;
   logic                 done_q,      done_d;
   logic                 clip_seen_q, clip_seen_d;
   logic                 overrun_q,   overrun_d;
   logic                 pend_v_q,    pend_v_d;
   logic [DATA_BITS-1:0] pend_data_q, pend_data_d;
   logic                 pend_clip_q, pend_clip_d;

   // State and datapath registers; reset abandons any frame immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         clip_seen_q <= 1'b0;
         overrun_q   <= 1'b0;
         pend_v_q    <= 1'b0;
         pend_data_q <= '0;
         pend_clip_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         clip_seen_q <= clip_seen_d;
         overrun_q   <= overrun_d;
         pend_v_q    <= pend_v_d;
         pend_data_q <= pend_data_d;
         pend_clip_q <= pend_clip_d;
      end
   end

   // Next-state, serialiser timing and pending-buffer control.
   always_comb begin
      logic                 start;
      logic [DATA_BITS-1:0] start_data;
      logic                 start_clip;
      logic                 capture;
      logic                 gap_exit;

      state_d     = state_q;
      shreg_d     = shreg_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      done_d      = 1'b0;
      clip_seen_d = clip_seen_q;
      overrun_d   = overrun_q;
      pend_v_d    = pend_v_q;
      pend_data_d = pend_data_q;
      pend_clip_d = pend_clip_q;
      start       = 1'b0;
      start_data  = bus.data;
      start_clip  = bus.clipped;
      capture     = 1'b0;
      gap_exit    = (gap_cnt_q == GAP_W'(CS_GAP - 1));

      unique case (state_q)
         IDLE: begin
            start = bus.update;
         end

         SHIFT: begin
            capture = bus.update;
            if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
               div_cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else if (bit_cnt_q == BIT_W'(F - 1)) begin
                  // Last high half-period done: close the frame.
                  sclk_d    = 1'b0;
                  cs_n_d    = 1'b1;
                  done_d    = 1'b1;
                  shreg_d   = '0;
                  gap_cnt_d = '0;
                  state_d   = GAP;
               end else begin
                  // Falling sclk edge is where mosi moves to the next bit.
                  sclk_d    = 1'b0;
                  shreg_d   = {shreg_q[F-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         GAP: begin
            if (gap_exit) begin
               if (pend_v_q) begin
                  // Pending word goes out; a coincident update refills the slot.
                  start      = 1'b1;
                  start_data = pend_data_q;
                  start_clip = pend_clip_q;
                  pend_v_d   = bus.update;
                  if (bus.update) begin
                     pend_data_d = bus.data;
                     pend_clip_d = bus.clipped;
                  end
               end else if (bus.update) begin
                  start = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
               capture   = bus.update;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Update while a frame or gap is in flight: newest word wins.
      if (capture) begin
         pend_data_d = bus.data;
         pend_clip_d = bus.clipped;
         pend_v_d    = 1'b1;
         if (pend_v_q) begin
            overrun_d = 1'b1;
         end
      end

      if (start) begin
         state_d     = SHIFT;
         shreg_d     = {CMD_WORD, start_data};
         clip_seen_d = clip_seen_q | start_clip;
         cs_n_d      = 1'b0;
         sclk_d      = 1'b0;
         div_cnt_d   = '0;
         bit_cnt_d   = '0;
      end

      busy_d = (state_d != IDLE);
   end

   assign bus.sclk      = sclk_q;
   assign bus.mosi      = shreg_q[F-1];
   assign bus.cs_n      = cs_n_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.clip_seen = clip_seen_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_dac_frame_writer.sv
// ----------------------------------------------------------------------------
// tb_dac_frame_writer
// Drives dac_frame_writer through single, clipped, back-to-back, overrun,
// mid-frame reset and gap-exit collision scenarios. A DAC model shifts mosi on
// each sclk rise while cs_n is low; completed frames are compared against an
// expected-frame queue filled when the stimulus is driven.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dac_frame_writer;

   localparam logic [7:0] CMD = 8'h30;

   logic clk;
   logic rst_n;

   dac_frame_writer_if #(.DATA_BITS(16)) bus ();

   dac_frame_writer #(
      .DATA_BITS(16), .CMD_BITS(8), .CMD_WORD(8'h30), .CLK_DIV(2), .CS_GAP(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected frames, pushed by the stimulus.
   logic [23:0] sb[$];

   // DAC model and timing monitor, sampled on the falling clk edge.
   int          cyc = 0;
   int          fall_cyc = 0, rise_cyc = 0, last_gap = -1;
   bit          have_rise = 0;
   int          bitcnt = 0;
   logic [23:0] cap = '0;
   int          frames = 0, dones = 0, busy_falls = 0, busy_fall_cyc = 0, viol = 0;
   logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_busy = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         bitcnt    = 0;
         cap       = '0;
         have_rise = 0;
      end else begin
         if (prev_cs && !bus.cs_n) begin
            if (have_rise) last_gap = cyc - rise_cyc;
            fall_cyc = cyc;
            bitcnt   = 0;
            cap      = '0;
         end
         if (!prev_sclk && bus.sclk && !bus.cs_n) begin
            cap = {cap[22:0], bus.mosi};
            bitcnt++;
         end
         if (prev_sclk && bus.sclk && (bus.mosi !== prev_mosi)) viol++;
         if (!prev_cs && bus.cs_n) begin
            chk("frame_bits", 64'(bitcnt), 64'd24);
            chk("cs_low_cycles", 64'(cyc - fall_cyc), 64'd96);
            if (sb.size() == 0) chk("unexpected_frame", 64'(cap), 64'hFFFF_FFFF);
            else chk("frame_data", 64'(cap), 64'(sb.pop_front()));
            rise_cyc  = cyc;
            have_rise = 1;
            frames++;
         end
         if (bus.done) dones++;
         if (prev_busy && !bus.busy) begin
            busy_falls++;
            busy_fall_cyc = cyc;
         end
      end
      prev_cs   = bus.cs_n;
      prev_sclk = bus.sclk;
      prev_mosi = bus.mosi;
      prev_busy = bus.busy;
   end

   // One-cycle update strobe, sampled by the DUT on the following rising edge.
   task automatic do_update(input logic [15:0] d, input logic c);
      @(posedge clk);
      #1;
      bus.update  = 1'b1;
      bus.data    = d;
      bus.clipped = c;
      @(posedge clk);
      #1;
      bus.update  = 1'b0;
      bus.data    = 16'hDEAD;
      bus.clipped = 1'b1;
   endtask

   task automatic wait_idle(input int max);
      int i;
      for (i = 0; i < max; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
      end
      if (i == max) chk("idle_timeout", 64'(bus.busy), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   int d0, f0, b0;

   initial begin
      rst_n       = 1'b0;
      bus.update  = 1'b0;
      bus.data    = '0;
      bus.clipped = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", 64'(bus.cs_n), 64'd1);
      chk("rst_sclk", 64'(bus.sclk), 64'd0);
      chk("rst_mosi", 64'(bus.mosi), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_clip_seen", 64'(bus.clip_seen), 64'd0);
      chk("rst_overrun", 64'(bus.overrun), 64'd0);
      rst_n = 1'b1;

      // Single word.
      d0 = dones;
      sb.push_back({CMD, 16'hA5C3});
      do_update(16'hA5C3, 1'b0);
      chk("busy_after_update", 64'(bus.busy), 64'd1);
      chk("cs_low_after_update", 64'(bus.cs_n), 64'd0);
      wait_idle(400);
      chk("single_done_pulses", 64'(dones - d0), 64'd1);
      chk("busy_fall_after_cs", 64'(busy_fall_cyc - rise_cyc), 64'd4);
      chk("single_clip_seen", 64'(bus.clip_seen), 64'd0);

      // Clip flag, sticky across a later unclipped frame.
      sb.push_back({CMD, 16'h7FFF});
      do_update(16'h7FFF, 1'b1);
      wait_idle(400);
      chk("clip_seen_set", 64'(bus.clip_seen), 64'd1);
      sb.push_back({CMD, 16'h1234});
      do_update(16'h1234, 1'b0);
      wait_idle(400);
      chk("clip_seen_sticky", 64'(bus.clip_seen), 64'd1);

      // Back-to-back: second word queued during the first frame.
      d0 = dones; f0 = frames; b0 = busy_falls;
      sb.push_back({CMD, 16'h0001});
      do_update(16'h0001, 1'b0);
      repeat (8) @(posedge clk);
      sb.push_back({CMD, 16'h0002});
      do_update(16'h0002, 1'b0);
      wait_idle(800);
      chk("b2b_gap", 64'(last_gap), 64'd4);
      chk("b2b_frames", 64'(frames - f0), 64'd2);
      chk("b2b_dones", 64'(dones - d0), 64'd2);
      chk("b2b_busy_falls", 64'(busy_falls - b0), 64'd1);
      chk("b2b_overrun", 64'(bus.overrun), 64'd0);

      // Overrun: middle word is overwritten and never sent.
      f0 = frames;
      sb.push_back({CMD, 16'h1111});
      do_update(16'h1111, 1'b0);
      repeat (5) @(posedge clk);
      do_update(16'h2222, 1'b0);
      chk("overrun_not_yet", 64'(bus.overrun), 64'd0);
      repeat (5) @(posedge clk);
      sb.push_back({CMD, 16'h3333});
      do_update(16'h3333, 1'b0);
      chk("overrun_set", 64'(bus.overrun), 64'd1);
      wait_idle(800);
      chk("overrun_frames", 64'(frames - f0), 64'd2);
      chk("overrun_sticky", 64'(bus.overrun), 64'd1);

      // Reset mid-frame clears everything at once.
      do_update(16'hCAFE, 1'b1);
      repeat (39) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_cs_n", 64'(bus.cs_n), 64'd1);
      chk("midrst_sclk", 64'(bus.sclk), 64'd0);
      chk("midrst_mosi", 64'(bus.mosi), 64'd0);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_clip_seen", 64'(bus.clip_seen), 64'd0);
      chk("midrst_overrun", 64'(bus.overrun), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      f0 = frames;
      sb.push_back({CMD, 16'hBEEF});
      do_update(16'hBEEF, 1'b0);
      wait_idle(400);
      chk("post_rst_frames", 64'(frames - f0), 64'd1);
      chk("post_rst_clip_seen", 64'(bus.clip_seen), 64'd0);

      // Update exactly on the gap-exit edge with nothing pending.
      b0 = busy_falls; f0 = frames;
      sb.push_back({CMD, 16'h5A5A});
      do_update(16'h5A5A, 1'b0);
      repeat (98) @(posedge clk);
      sb.push_back({CMD, 16'hC001});
      do_update(16'hC001, 1'b0);
      chk("collide_busy", 64'(bus.busy), 64'd1);
      chk("collide_cs_n", 64'(bus.cs_n), 64'd0);
      wait_idle(400);
      chk("collide_gap", 64'(last_gap), 64'd4);
      chk("collide_busy_falls", 64'(busy_falls - b0), 64'd1);
      chk("collide_frames", 64'(frames - f0), 64'd2);

      chk("mosi_stable_sclk_high", 64'(viol), 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
